// File: rtl/clk_rst_gen.sv
// Divided system clock, lock/reset-stretch sequencer and debounced push button,
// all clocked by clk_50M.
module clk_rst_gen #(
    parameter int unsigned DIV             = 5,
    parameter int unsigned LOCK_CYCLES     = 1024,
    parameter int unsigned RST_STRETCH     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_50M,
    input  logic reset_btn,
    input  logic push_btn,
    output logic clk_sys,
    output logic clk_sys_en,
    output logic locked,
    output logic sys_rst,
    output logic btn_level,
    output logic btn_pulse
);
    localparam int unsigned DIV_W  = $clog2(DIV);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned STR_W  = $clog2(RST_STRETCH + 1);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(DIV / 2);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(RST_STRETCH - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_STRETCH,
        S_RUN
    } state_t;

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    state_t            state;
    state_t            state_nxt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_cnt_nxt;
    logic [STR_W-1:0]  stretch_cnt;
    logic [STR_W-1:0]  stretch_cnt_nxt;
    logic              locked_nxt;
    logic              sys_rst_nxt;
    logic              sync_q1;
    logic              sync_q2;
    logic [DEB_W-1:0]  deb_cnt;
    logic              btn_toggle;
    logic              btn_rise;
    logic              pending;

    // Divider: clk_sys is high for the first DIV/2 counts of each period
    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            div_cnt    <= DIV_LAST;
            clk_sys    <= 1'b0;
            clk_sys_en <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            clk_sys    <= (div_nxt < DIV_HALF);
            clk_sys_en <= (div_nxt == DIV_LAST);
        end
    end

    // Lock/stretch sequencer state register
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            state       <= S_WAIT;
            lock_cnt    <= '0;
            stretch_cnt <= '0;
            locked      <= 1'b0;
            sys_rst     <= 1'b1;
        end else begin
            state       <= state_nxt;
            lock_cnt    <= lock_cnt_nxt;
            stretch_cnt <= stretch_cnt_nxt;
            locked      <= locked_nxt;
            sys_rst     <= sys_rst_nxt;
        end
    end

    // Stretch only advances on clk_sys_en so sys_rst drops on a clk_sys rising edge
    always_comb begin
        state_nxt       = state;
        lock_cnt_nxt    = lock_cnt;
        stretch_cnt_nxt = stretch_cnt;
        locked_nxt      = locked;
        sys_rst_nxt     = sys_rst;
        case (state)
            S_WAIT: begin
                lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                if (lock_cnt == LOCK_LAST) begin
                    state_nxt  = S_STRETCH;
                    locked_nxt = 1'b1;
                end
            end
            S_STRETCH: begin
                if (clk_sys_en) begin
                    if (stretch_cnt == STR_LAST) begin
                        state_nxt   = S_RUN;
                        sys_rst_nxt = 1'b0;
                    end else begin
                        stretch_cnt_nxt = stretch_cnt + STR_W'(1);
                    end
                end
            end
            S_RUN: begin
                locked_nxt  = 1'b1;
                sys_rst_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

    always_comb begin
        btn_toggle = (sync_q2 != btn_level) && (deb_cnt == DEB_LAST);
        btn_rise   = btn_toggle && !btn_level;
    end

    // Synchronizer and debounce: level flips after DEBOUNCE_CYCLES mismatching samples
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            deb_cnt   <= '0;
            btn_level <= 1'b0;
        end else begin
            sync_q1 <= push_btn;
            sync_q2 <= sync_q1;
            if (sync_q2 == btn_level) begin
                deb_cnt <= '0;
            end else if (btn_toggle) begin
                deb_cnt   <= '0;
                btn_level <= ~btn_level;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Press -> one clk_sys-period pulse; presses while busy are ignored
    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            pending   <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            if (clk_sys_en) begin
                if (btn_pulse) begin
                    btn_pulse <= 1'b0;
                end else if (pending) begin
                    btn_pulse <= 1'b1;
                    pending   <= 1'b0;
                end
            end
            if (btn_rise && (state == S_RUN) && !pending && !btn_pulse) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Self-checking bench for clk_rst_gen: vector table, directed corner cases and
// randomized button/reset stimulus against a time-based reference model.
module tb_clk_rst_gen;
    localparam int LOCK = 8;
    localparam int STR  = 2;
    localparam int DEB  = 4;

    logic clk_50M = 1'b0;
    logic reset_btn;
    logic push_btn;
    logic clk_sys, clk_sys_en, locked, sys_rst, btn_level, btn_pulse;
    logic clk_sys4, clk_sys_en4, locked4, sys_rst4, btn_level4, btn_pulse4;

    clk_rst_gen #(.DIV(5), .LOCK_CYCLES(LOCK), .RST_STRETCH(STR), .DEBOUNCE_CYCLES(DEB)) u_dut (
        .clk_50M(clk_50M), .reset_btn(reset_btn), .push_btn(push_btn),
        .clk_sys(clk_sys), .clk_sys_en(clk_sys_en), .locked(locked),
        .sys_rst(sys_rst), .btn_level(btn_level), .btn_pulse(btn_pulse)
    );

    clk_rst_gen #(.DIV(4), .LOCK_CYCLES(LOCK), .RST_STRETCH(STR), .DEBOUNCE_CYCLES(DEB)) u_dut4 (
        .clk_50M(clk_50M), .reset_btn(reset_btn), .push_btn(push_btn),
        .clk_sys(clk_sys4), .clk_sys_en(clk_sys_en4), .locked(locked4),
        .sys_rst(sys_rst4), .btn_level(btn_level4), .btn_pulse(btn_pulse4)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct packed {
        bit push;
        bit clk;
        bit en;
        bit lock;
        bit rst;
    } vec_t;
    vec_t vecs[20];

    int checks = 0;
    int errors = 0;

    // Reference model: everything derived from t = edges since reset release
    int divs[2] = '{5, 4};
    int t;
    int trun[2];
    int pst[2];
    int pen[2];
    bit samp_q[$];
    bit win_q[$];
    bit m_level;

    function automatic int calc_trun(int d);
        int n = 0;
        for (int e = 1 + d; e < 100000; e += d) begin
            if (e > LOCK) begin
                n++;
                if (n == STR) return e;
            end
        end
        return -1;
    endfunction

    function automatic int next_en(int tt, int d);
        return 1 + d * ((tt - 1) / d + 1);
    endfunction

    function automatic bit e_clk(int k);
        return (t >= 1) && (((t - 1) % divs[k]) < (divs[k] / 2));
    endfunction

    function automatic bit e_en(int k);
        return (t >= 1) && (((t - 1) % divs[k]) == divs[k] - 1);
    endfunction

    function automatic bit e_pulse(int k);
        return (pen[k] >= 0) && (t >= pst[k]) && (t < pen[k]);
    endfunction

    task automatic model_reset();
        t = 0;
        samp_q.delete();
        win_q.delete();
        m_level = 1'b0;
        pen = '{-1, -1};
        pst = '{0, 0};
    endtask

    task automatic model_edge();
        bit c;
        bit all_diff;
        t++;
        c = (samp_q.size() >= 2) ? samp_q[1] : 1'b0;
        samp_q.push_front(push_btn);
        while (samp_q.size() > 2) void'(samp_q.pop_back());
        win_q.push_front(c);
        while (win_q.size() > DEB) void'(win_q.pop_back());
        all_diff = (win_q.size() == DEB);
        foreach (win_q[i]) if (win_q[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = !m_level;
            if (m_level) begin
                for (int k = 0; k < 2; k++) begin
                    if (t > trun[k] && !(pen[k] >= 0 && t <= pen[k])) begin
                        pst[k] = next_en(t, divs[k]);
                        pen[k] = pst[k] + divs[k];
                    end
                end
            end
        end
    endtask

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %b expected %b", name, t, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("clk_sys", clk_sys, e_clk(0));
        chk("clk_sys_en", clk_sys_en, e_en(0));
        chk("locked", locked, t >= LOCK);
        chk("sys_rst", sys_rst, t < trun[0]);
        chk("btn_level", btn_level, m_level);
        chk("btn_pulse", btn_pulse, e_pulse(0));
        chk("clk_sys/4", clk_sys4, e_clk(1));
        chk("clk_sys_en/4", clk_sys_en4, e_en(1));
        chk("locked/4", locked4, t >= LOCK);
        chk("sys_rst/4", sys_rst4, t < trun[1]);
        chk("btn_level/4", btn_level4, m_level);
        chk("btn_pulse/4", btn_pulse4, e_pulse(1));
    endtask

    // One clk_50M edge; outputs compared 1 time unit after it
    task automatic tick();
        @(posedge clk_50M);
        if (reset_btn) model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset_btn = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic run_table();
        int en4_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            push_btn = vecs[i].push;
            tick();
            chk("tbl_clk_sys", clk_sys, vecs[i].clk);
            chk("tbl_clk_sys_en", clk_sys_en, vecs[i].en);
            chk("tbl_locked", locked, vecs[i].lock);
            chk("tbl_sys_rst", sys_rst, vecs[i].rst);
            if (clk_sys_en4) en4_cnt++;
        end
        chk_int("div4_en_count", en4_cnt, 5);
    endtask

    initial begin
        bit [0:19] p_clk  = 20'b11000110001100011000;
        bit [0:19] p_en   = 20'b00001000010000100001;
        bit [0:19] p_lock = 20'b00000001111111111111;
        bit [0:19] p_rst  = 20'b11111111111111100000;
        int t0, lvl_t, rise_t, pcnt, seen;
        logic clk_at_rise;

        for (int i = 0; i < 20; i++) vecs[i] = '{1'b0, p_clk[i], p_en[i], p_lock[i], p_rst[i]};
        trun[0] = calc_trun(divs[0]);
        trun[1] = calc_trun(divs[1]);

        reset_btn = 1'b0;
        push_btn  = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_btn = 1'b1;
        run_table();

        // Glitch shorter than the debounce window
        seen = 0;
        push_btn = 1'b1;
        repeat (3) begin tick(); if (btn_level || btn_pulse) seen++; end
        push_btn = 1'b0;
        repeat (10) begin tick(); if (btn_level || btn_pulse) seen++; end
        chk_int("glitch_ignored", seen, 0);

        // Held press: latency, width and alignment of the pulse
        t0 = t; lvl_t = -1; rise_t = -1; pcnt = 0; clk_at_rise = 1'b0;
        push_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (btn_level && lvl_t < 0) lvl_t = t;
            if (btn_pulse) begin
                if (rise_t < 0) begin rise_t = t; clk_at_rise = clk_sys; end
                pcnt++;
            end
        end
        chk_int("level_latency", lvl_t - t0, 6);
        chk_int("pulse_width", pcnt, 5);
        chk("pulse_rise_clk", clk_at_rise, 1'b1);

        // Release shorter than the window, then press again: no second pulse
        pcnt = 0;
        push_btn = 1'b0;
        repeat (2) tick();
        push_btn = 1'b1;
        repeat (30) begin tick(); if (btn_pulse) pcnt++; end
        chk_int("no_second_pulse", pcnt, 0);
        push_btn = 1'b0;
        repeat (12) tick();

        // Reset mid-pulse, then the full sequence again
        seen = 0;
        push_btn = 1'b1;
        for (int i = 0; i < 40 && seen == 0; i++) begin tick(); if (btn_pulse) seen = 1; end
        chk_int("pulse_before_reset", seen, 1);
        async_reset();
        chk("reset_pulse", btn_pulse, 1'b0);
        chk("reset_sys_rst", sys_rst, 1'b1);
        push_btn = 1'b0;
        tick();
        reset_btn = 1'b1;
        run_table();

        // Button held from reset through lock: level rises, pulse never fires
        async_reset();
        push_btn = 1'b1;
        repeat (2) tick();
        reset_btn = 1'b1;
        seen = 0;
        repeat (30) begin tick(); if (btn_pulse) seen++; end
        chk("held_level", btn_level, 1'b1);
        chk_int("held_no_pulse", seen, 0);
        push_btn = 1'b0;
        repeat (10) tick();

        // Random button activity with occasional resets
        for (int n = 0; n < 120; n++) begin
            push_btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) tick();
            if ($urandom_range(0, 29) == 0) begin
                async_reset();
                repeat ($urandom_range(1, 3)) tick();
                reset_btn = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_rst_gen.md
CLK_RST_GEN -- requirements
Module: clk_rst_gen

Interface
REQ-001 SHALL have parameter DIV, default 5: clk_50M cycles per clk_sys period (legal 2..16).
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024: clk_50M cycles from reset release to locked (legal >=1).
REQ-003 SHALL have parameter RST_STRETCH, default 16: clk_sys periods sys_rst is held after locked (legal >=1).
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clk_50M samples needed to accept a push_btn change (legal >=1).
REQ-005 SHALL have port clk_50M, input, 1: sole clock; all flops on its rising edge.
REQ-006 SHALL have port reset_btn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port push_btn, input, 1: raw asynchronous button, active high.
REQ-008 SHALL have port clk_sys, output, 1: divided system clock, flop-driven.
REQ-009 SHALL have port clk_sys_en, output, 1: clk_50M-domain strobe, high in the cycle before each clk_sys rising edge.
REQ-010 SHALL have port locked, output, 1: clock generation stable.
REQ-011 SHALL have port sys_rst, output, 1: active-high system reset for the clk_sys domain.
REQ-012 SHALL have port btn_level, output, 1: debounced push_btn level.
REQ-013 SHALL have port btn_pulse, output, 1: one-clk_sys-period pulse per debounced press.

Function
REQ-014 Divider: div_cnt counts 0..DIV-1 and wraps to 0; each edge, clk_sys <= (next div_cnt < floor(DIV/2)), giving 2 high / 3 low for DIV=5 and 2/2 for DIV=4.
REQ-015 clk_sys_en SHALL be registered and high exactly in cycles where div_cnt == DIV-1, so the edge that ends it is the clk_sys rising edge.
REQ-016 FSM SHALL have states S_WAIT, S_STRETCH, S_RUN; reset state S_WAIT.
REQ-017 S_WAIT: lock_cnt increments every clk_50M edge; on the edge where lock_cnt == LOCK_CYCLES-1, go to S_STRETCH and set locked=1.
REQ-018 S_STRETCH: stretch_cnt increments only on edges where clk_sys_en=1; on the clk_sys_en edge where stretch_cnt == RST_STRETCH-1, go to S_RUN and clear sys_rst, so deassertion coincides with a clk_sys rising edge.
REQ-019 S_RUN SHALL be absorbing until reset; locked=1, sys_rst=0.
REQ-020 push_btn SHALL pass through a 2-flop synchronizer before use.
REQ-021 Debounce: deb_cnt increments while the synchronized sample != btn_level and clears when they are equal; when it reaches DEBOUNCE_CYCLES-1 with a mismatch, btn_level toggles and deb_cnt clears.
REQ-022 deb_cnt width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) and SHALL never wrap.
REQ-023 A 0->1 btn_level transition in S_RUN SHALL set a pending flag; transitions outside S_RUN SHALL be dropped.
REQ-024 btn_pulse SHALL rise on the next clk_sys_en edge with pending=1, clearing pending, and fall on the following clk_sys_en edge (high exactly DIV clk_50M cycles).
REQ-025 A new press while pending or btn_pulse is set SHALL not lengthen or duplicate the pulse.
REQ-026 A press whose release is shorter than the debounce window SHALL produce no second pulse.

Reset
REQ-027 reset_btn low SHALL immediately and asynchronously force: div_cnt=DIV-1, clk_sys=0, clk_sys_en=0, locked=0, sys_rst=1, btn_level=0, btn_pulse=0, all counters 0, pending=0, synchronizer=0, state S_WAIT.
REQ-028 reset_btn asserted in any state, including mid-pulse or mid-stretch, SHALL restart the full lock/stretch sequence after release.
REQ-029 After release, the first edge SHALL set div_cnt=0 and clk_sys=1.

Verification (DIV=5, LOCK_CYCLES=8, RST_STRETCH=2, DEBOUNCE_CYCLES=4 unless stated)
REQ-030 Release reset -> clk_sys 1,1,0,0,0 repeating from edge 1; locked=1 after edge 8; sys_rst=0 exactly at the 2nd clk_sys rising edge after lock.
REQ-031 push_btn high for 3 cycles in S_RUN -> btn_level and btn_pulse stay 0.
REQ-032 push_btn held high -> btn_level=1 at 2+4 cycles after the input change; btn_pulse high for exactly 5 cycles, rising with clk_sys.
REQ-033 push_btn held from time 0 through lock -> btn_level=1, btn_pulse never asserts.
REQ-034 reset_btn low for 1 cycle mid-btn_pulse in S_RUN -> outputs at reset values within the same cycle; sequence per REQ-030 repeats.
REQ-035 DIV=4 -> clk_sys 1,1,0,0 pattern; clk_sys_en high every 4th cycle, once per period.
